// File: rtl/latch_bus_sequencer_pkg.sv
// Shared definitions for the ttl373 latch bus sequencer: state encoding and sizing helpers.
package latch_bus_sequencer_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LATCH = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRIVE = 3'd4
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/latch_bus_sequencer_timer.sv
// Loadable down-counter with a zero flag; one instance is shared by every timed state.
module latch_bus_sequencer_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/latch_bus_sequencer.sv
// Drives D/LE/OE_n of a ttl373 latch: timed write strobes with setup/hold margins and
// level-held read windows, never enabling LE and the latch outputs at the same time.
module latch_bus_sequencer
  import latch_bus_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int SETUP_CYCLES = 1,
  parameter int LE_CYCLES    = 2,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  WR_REQ,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  RD_REQ,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [DATA_WIDTH-1:0] D,
  output logic                  LE,
  output logic                  OE_n
);

  localparam int S_EFF = (SETUP_CYCLES > 0) ? SETUP_CYCLES : 0;
  localparam int L_EFF = (LE_CYCLES < 1) ? 1 : LE_CYCLES;
  localparam int H_EFF = (HOLD_CYCLES > 0) ? HOLD_CYCLES : 0;
  localparam int MAX_C = max3(S_EFF, L_EFF, H_EFF);
  localparam int CNT_W = ($clog2(MAX_C + 1) < 1) ? 1 : $clog2(MAX_C + 1);

  // The timer is loaded with N-1 on entry so a state lasts exactly N cycles.
  localparam logic [CNT_W-1:0] S_LOAD = CNT_W'((S_EFF > 0) ? S_EFF - 1 : 0);
  localparam logic [CNT_W-1:0] L_LOAD = CNT_W'(L_EFF - 1);
  localparam logic [CNT_W-1:0] H_LOAD = CNT_W'((H_EFF > 0) ? H_EFF - 1 : 0);
  localparam logic HAS_SETUP = (S_EFF > 0);
  localparam logic HAS_HOLD  = (H_EFF > 0);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] d_q, d_d;
  logic                  le_q, le_d;
  logic                  oe_n_q, oe_n_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  tmr_load;
  logic [CNT_W-1:0]      tmr_value;
  logic                  tmr_zero;

  latch_bus_sequencer_timer #(
    .WIDTH(CNT_W)
  ) u_timer (
    .clk       (CLK),
    .reset     (RESET),
    .load      (tmr_load),
    .load_value(tmr_value),
    .zero      (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    d_d       = d_q;
    le_d      = 1'b0;
    oe_n_d    = 1'b1;
    done_d    = 1'b0;
    busy_d    = 1'b1;
    tmr_load  = 1'b0;
    tmr_value = '0;
    case (state_q)
      ST_IDLE: begin
        if (WR_REQ) begin
          d_d      = WR_DATA;
          tmr_load = 1'b1;
          if (HAS_SETUP) begin
            state_d   = ST_SETUP;
            tmr_value = S_LOAD;
          end else begin
            state_d   = ST_LATCH;
            le_d      = 1'b1;
            tmr_value = L_LOAD;
          end
        end else if (RD_REQ) begin
          state_d = ST_DRIVE;
          oe_n_d  = 1'b0;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_SETUP: begin
        if (tmr_zero) begin
          state_d   = ST_LATCH;
          le_d      = 1'b1;
          tmr_load  = 1'b1;
          tmr_value = L_LOAD;
        end
      end
      ST_LATCH: begin
        if (!tmr_zero) begin
          le_d = 1'b1;
        end else if (HAS_HOLD) begin
          state_d   = ST_HOLD;
          tmr_load  = 1'b1;
          tmr_value = H_LOAD;
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      ST_HOLD: begin
        if (tmr_zero) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      ST_DRIVE: begin
        if (RD_REQ) begin
          oe_n_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      d_q     <= '0;
      le_q    <= 1'b0;
      oe_n_q  <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      le_q    <= le_d;
      oe_n_q  <= oe_n_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign D    = d_q;
  assign LE   = le_q;
  assign OE_n = oe_n_q;

endmodule
